// File: rtl/wave_pkg.sv
// Shared wave-mode codes, sample constants and FSM encoding for the wave selector/generator pair.
package wave_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned MODE_W   = 3;

  localparam logic [MODE_W-1:0] WM_SAW      = 3'd0;
  localparam logic [MODE_W-1:0] WM_SQUARE   = 3'd1;
  localparam logic [MODE_W-1:0] WM_REV      = 3'd2;
  localparam logic [MODE_W-1:0] WM_TRIANGLE = 3'd3;
  localparam logic [MODE_W-1:0] WM_SINE     = 3'd4;
  localparam logic [MODE_W-1:0] WM_TRUMPET  = 3'd5;
  localparam logic [MODE_W-1:0] WM_VIOLIN   = 3'd6;

  localparam logic [SAMPLE_W-1:0] SAMPLE_MID = 8'd128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LK1  = 2'd1,
    ST_LK2  = 2'd2,
    ST_MIX  = 2'd3
  } state_t;

  // Quarter-wave LUT address for an 8-bit phase (second quarter mirrored).
  function automatic logic [5:0] sine_index(input logic [7:0] x);
    return x[6] ? ~x[5:0] : x[5:0];
  endfunction

  // Unfold a quarter-wave amplitude into a full unsigned sine sample.
  function automatic logic [7:0] sine_fold(input logic lower_half, input logic [6:0] amp);
    return lower_half ? (8'd127 - 8'(amp)) : (8'd128 + 8'(amp));
  endfunction

endpackage

// File: rtl/wave_generator_sine_quarter_lut.sv
// Combinational 64x7 quarter-wave ROM: round(127*sin(pi*(2i+1)/256)).
module sine_quarter_lut
  import wave_pkg::*;
(
  input  logic [5:0] idx,
  output logic [6:0] amp
);

  always_comb begin
    amp = 7'd0;
    case (idx)
      6'd0:  amp = 7'd2;   6'd1:  amp = 7'd5;   6'd2:  amp = 7'd8;   6'd3:  amp = 7'd11;
      6'd4:  amp = 7'd14;  6'd5:  amp = 7'd17;  6'd6:  amp = 7'd20;  6'd7:  amp = 7'd23;
      6'd8:  amp = 7'd26;  6'd9:  amp = 7'd29;  6'd10: amp = 7'd32;  6'd11: amp = 7'd35;
      6'd12: amp = 7'd38;  6'd13: amp = 7'd41;  6'd14: amp = 7'd44;  6'd15: amp = 7'd47;
      6'd16: amp = 7'd50;  6'd17: amp = 7'd53;  6'd18: amp = 7'd56;  6'd19: amp = 7'd58;
      6'd20: amp = 7'd61;  6'd21: amp = 7'd64;  6'd22: amp = 7'd67;  6'd23: amp = 7'd69;
      6'd24: amp = 7'd72;  6'd25: amp = 7'd74;  6'd26: amp = 7'd77;  6'd27: amp = 7'd79;
      6'd28: amp = 7'd82;  6'd29: amp = 7'd84;  6'd30: amp = 7'd86;  6'd31: amp = 7'd89;
      6'd32: amp = 7'd91;  6'd33: amp = 7'd93;  6'd34: amp = 7'd95;  6'd35: amp = 7'd97;
      6'd36: amp = 7'd99;  6'd37: amp = 7'd101; 6'd38: amp = 7'd103; 6'd39: amp = 7'd105;
      6'd40: amp = 7'd106; 6'd41: amp = 7'd108; 6'd42: amp = 7'd110; 6'd43: amp = 7'd111;
      6'd44: amp = 7'd113; 6'd45: amp = 7'd114; 6'd46: amp = 7'd115; 6'd47: amp = 7'd117;
      6'd48: amp = 7'd118; 6'd49: amp = 7'd119; 6'd50: amp = 7'd120; 6'd51: amp = 7'd121;
      6'd52: amp = 7'd122; 6'd53: amp = 7'd123; 6'd54: amp = 7'd124; 6'd55: amp = 7'd124;
      6'd56: amp = 7'd125; 6'd57: amp = 7'd125; 6'd58: amp = 7'd126; 6'd59: amp = 7'd126;
      6'd60: amp = 7'd127; 6'd61: amp = 7'd127; 6'd62: amp = 7'd127; 6'd63: amp = 7'd127;
      default: amp = 7'd0;
    endcase
  end

endmodule

// File: rtl/wave_generator.sv
// Phase-accumulator waveform source: one 8-bit unsigned sample per SAMPLE_DIV clocks,
// computed over IDLE->LK1->LK2->MIX with a single shared sine LUT.
module wave_generator
  import wave_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 227,
  parameter int unsigned PHASE_W    = 16
) (
  input  logic               MHz10,
  input  logic               nrst,
  input  logic               en,
  input  logic [2:0]         wave_mode,
  input  logic [PHASE_W-1:0] phase_inc,
  output logic [7:0]         sample,
  output logic               sample_valid
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0]   count;
  logic               tick_c;
  logic [PHASE_W-1:0] phase_acc;
  logic [2:0]         mode_r;
  logic [7:0]         p_r;
  logic [7:0]         sin1_r;
  logic [7:0]         sin2_r;
  state_t             state;
  state_t             state_next;

  logic [7:0] lut_x_c;
  logic [5:0] lut_idx_c;
  logic [6:0] lut_amp_c;
  logic [7:0] sine_c;
  logic [7:0] tri_c;
  logic [8:0] trumpet_sum_c;
  logic [8:0] violin_sum_c;
  logic [7:0] mix_c;

  assign tick_c = en && (count == CNT_LAST);

  // Sample-rate divider; held at zero while disabled.
  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst)                count <= '0;
    else if (!en)             count <= '0;
    else if (count == CNT_LAST) count <= '0;
    else                      count <= count + CNT_W'(1);
  end

  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst)    state <= ST_IDLE;
    else if (!en) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (tick_c) state_next = ST_LK1;
      ST_LK1:  state_next = ST_LK2;
      ST_LK2:  state_next = ST_MIX;
      ST_MIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // LK1 looks up the fundamental, LK2 the doubled phase for the violin overtone.
  assign lut_x_c   = (state == ST_LK2) ? {p_r[6:0], 1'b0} : p_r;
  assign lut_idx_c = sine_index(lut_x_c);
  assign sine_c    = sine_fold(lut_x_c[7], lut_amp_c);

  sine_quarter_lut u_lut (
    .idx (lut_idx_c),
    .amp (lut_amp_c)
  );

  assign tri_c         = p_r[7] ? ~{p_r[6:0], 1'b0} : {p_r[6:0], 1'b0};
  assign trumpet_sum_c = 9'(p_r) + 9'(sin1_r);
  assign violin_sum_c  = 9'(tri_c) + 9'(sin2_r);

  always_comb begin
    mix_c = SAMPLE_MID;
    case (mode_r)
      WM_SAW:      mix_c = p_r;
      WM_SQUARE:   mix_c = p_r[7] ? 8'd0 : 8'd255;
      WM_REV:      mix_c = ~p_r;
      WM_TRIANGLE: mix_c = tri_c;
      WM_SINE:     mix_c = sin1_r;
      WM_TRUMPET:  mix_c = trumpet_sum_c[8:1];
      WM_VIOLIN:   mix_c = violin_sum_c[8:1];
      default:     mix_c = SAMPLE_MID;
    endcase
  end

  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      phase_acc    <= '0;
      mode_r       <= WM_SAW;
      p_r          <= '0;
      sin1_r       <= '0;
      sin2_r       <= '0;
      sample       <= SAMPLE_MID;
      sample_valid <= 1'b0;
    end else if (!en) begin
      phase_acc    <= '0;
      sample       <= SAMPLE_MID;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        ST_IDLE: if (tick_c) begin
          mode_r    <= wave_mode;
          p_r       <= phase_acc[PHASE_W-1 -: 8];
          phase_acc <= phase_acc + phase_inc;
        end
        ST_LK1: sin1_r <= sine_c;
        ST_LK2: sin2_r <= sine_c;
        ST_MIX: begin
          sample       <= mix_c;
          sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_generator.sv
// Directed self-checking bench for wave_generator with a short sample period (SAMPLE_DIV = 5).
module tb_wave_generator;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic [2:0]  wave_mode;
  logic [15:0] phase_inc;
  logic [7:0]  sample;
  logic        sample_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wave_generator #(.SAMPLE_DIV(5), .PHASE_W(16)) dut (
    .MHz10        (clk),
    .nrst         (nrst),
    .en           (en),
    .wave_mode    (wave_mode),
    .phase_inc    (phase_inc),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count clock edges until sample_valid is seen (bounded).
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!sample_valid && n < 40);
    if (!sample_valid) begin
      check({tag, "_timeout"}, 32'(sample_valid), 32'd1);
      n = -1;
    end
  endtask

  task automatic expect_sample(input string tag, input int gap, input logic [7:0] val);
    int n;
    wait_valid(tag, n);
    check({tag, "_gap"}, n, gap);
    check(tag, 32'(sample), 32'(val));
  endtask

  task automatic restart(input logic [2:0] mode, input logic [15:0] inc);
    en = 1'b0;
    step(1);
    wave_mode = mode;
    phase_inc = inc;
    en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcount;
    nrst      = 1'b0;
    en        = 1'b0;
    wave_mode = 3'd0;
    phase_inc = 16'h0100;
    step(3);
    check("rst_sample", 32'(sample), 32'd128);
    check("rst_valid", 32'(sample_valid), 32'd0);

    // Saw: first valid at SAMPLE_DIV+3 edges, then one every SAMPLE_DIV.
    en   = 1'b1;
    nrst = 1'b1;
    expect_sample("saw0", 8, 8'd0);
    step(1);
    check("valid_width", 32'(sample_valid), 32'd0);
    expect_sample("saw1", 4, 8'd1);
    expect_sample("saw2", 5, 8'd2);
    expect_sample("saw3", 5, 8'd3);

    en = 1'b0;
    step(1);
    check("en_low_sample", 32'(sample), 32'd128);
    check("en_low_valid", 32'(sample_valid), 32'd0);

    wave_mode = 3'd1;
    phase_inc = 16'h4000;
    en        = 1'b1;
    expect_sample("sq0", 8, 8'd255);
    expect_sample("sq1", 5, 8'd255);
    expect_sample("sq2", 5, 8'd0);
    expect_sample("sq3", 5, 8'd0);
    expect_sample("sq4", 5, 8'd255);

    restart(3'd3, 16'h4000);
    expect_sample("tri0", 8, 8'h00);
    expect_sample("tri1", 5, 8'h80);
    expect_sample("tri2", 5, 8'hFF);
    expect_sample("tri3", 5, 8'h7F);

    restart(3'd4, 16'h4000);
    expect_sample("sin0", 8, 8'd130);
    expect_sample("sin64", 5, 8'd255);
    expect_sample("sin128", 5, 8'd125);
    expect_sample("sin192", 5, 8'd0);

    restart(3'd6, 16'h4000);
    expect_sample("vio0", 8, 8'd65);
    expect_sample("vio64", 5, 8'd126);
    wave_mode = 3'd7;
    expect_sample("mode7", 5, 8'd128);
    wave_mode = 3'd5;
    expect_sample("tru192", 5, 8'd96);

    restart(3'd5, 16'h4000);
    expect_sample("tru0", 8, 8'd65);
    expect_sample("tru64", 5, 8'd159);

    // Mode change while in LK2 only affects the following sample.
    restart(3'd0, 16'h1000);
    expect_sample("lk2_saw0", 8, 8'd0);
    step(3);
    wave_mode = 3'd2;
    expect_sample("lk2_saw16", 2, 8'd16);
    expect_sample("lk2_rev32", 5, 8'd223);

    // Disable during LK1 aborts the sample and clears the phase.
    step(2);
    en = 1'b0;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (sample_valid) vcount++;
    end
    check("abort_valids", vcount, 0);
    check("abort_sample", 32'(sample), 32'd128);
    wave_mode = 3'd0;
    phase_inc = 16'h1000;
    en        = 1'b1;
    expect_sample("abort_phase0", 8, 8'd0);
    expect_sample("abort_phase16", 5, 8'd16);

    // Reset during MIX clears outputs without waiting for a clock.
    step(4);
    nrst = 1'b0;
    #1;
    check("rst_mix_sample", 32'(sample), 32'd128);
    check("rst_mix_valid", 32'(sample_valid), 32'd0);
    step(2);
    nrst = 1'b1;
    expect_sample("post_rst0", 8, 8'd0);

    // Zero increment repeats the same phase every sample.
    phase_inc = 16'h0000;
    expect_sample("zero_inc0", 5, 8'd16);
    expect_sample("zero_inc1", 5, 8'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
